// File: rtl/pe_job_sequencer_pkg.sv
// Shared types for the PE job sequencer: FSM state encoding, error codes and
// default widths that match the Processing_element configuration ports.
package pe_job_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } seq_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_BAD_CFG = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam int DEF_STRIDE_WIDTH      = 2;
  localparam int DEF_FILTER_SIZE_WIDTH = 3;
  localparam int DEF_DATA_WIDTH        = 16;
  localparam int DEF_COUNT_WIDTH       = 8;
  localparam int DEF_TIMEOUT_WIDTH     = 12;

  // Psums may be drained while the PE is still producing as well as afterwards.
  function automatic logic is_drain_phase(seq_state_e s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/pe_job_sequencer_psum_drain_counter.sv
// Drains the Psum FIFO to the output port, counting accepted beats so that no
// more than the job's Psum count ever leaves and the final beat is flagged.
module psum_drain_counter
  import pe_job_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [COUNT_WIDTH-1:0] count_i,
  input  logic                   buf_valid_i,
  input  logic [DATA_WIDTH-1:0]  buf_dout_i,
  input  logic                   out_ready_i,
  output logic                   out_valid_o,
  output logic [DATA_WIDTH-1:0]  out_data_o,
  output logic                   out_last_o,
  output logic                   buf_ren_o,
  output logic                   drain_done_o
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] drn_cnt_q, drn_cnt_d;

  assign out_valid_o  = en_i & buf_valid_i & (drn_cnt_q < count_i);
  assign out_data_o   = buf_dout_i;
  assign out_last_o   = out_valid_o & (drn_cnt_q == (count_i - CNT_ONE));
  assign buf_ren_o    = out_valid_o & out_ready_i;
  assign drain_done_o = (drn_cnt_q == count_i);

  always_comb begin
    drn_cnt_d = drn_cnt_q;
    if (clr_i) begin
      drn_cnt_d = '0;
    end else if (buf_ren_o) begin
      drn_cnt_d = drn_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drn_cnt_q <= '0;
    end else begin
      drn_cnt_q <= drn_cnt_d;
    end
  end

endmodule

// File: rtl/pe_job_sequencer.sv
// Runs one Processing_element job at a time: latches the descriptor, starts the
// PE, counts its Psum writes under a watchdog and drains the Psum FIFO.
//
// state | meaning
// IDLE  | waiting for a descriptor (ready only while no error is pending)
// LOAD  | PE config registers settle
// START | one-cycle Start to the PE
// RUN   | counting PE Psum writes, draining concurrently, watchdog armed
// DRAIN | all Psums produced, emptying the remaining beats
// DONE  | one-cycle done pulse
// ERR   | bad config or timeout; waits for err_clear
module pe_job_sequencer
  import pe_job_sequencer_pkg::*;
#(
  parameter int STRIDE_WIDTH      = DEF_STRIDE_WIDTH,
  parameter int FILTER_SIZE_WIDTH = DEF_FILTER_SIZE_WIDTH,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH       = DEF_COUNT_WIDTH,
  parameter int TIMEOUT_WIDTH     = DEF_TIMEOUT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [STRIDE_WIDTH-1:0]      job_stride,
  input  logic [FILTER_SIZE_WIDTH-1:0] job_filter_size,
  input  logic [COUNT_WIDTH-1:0]       job_psum_count,
  output logic                         pe_start,
  output logic [STRIDE_WIDTH-1:0]      pe_stride,
  output logic [FILTER_SIZE_WIDTH-1:0] pe_filter_size,
  input  logic                         pe_wen_psum,
  input  logic                         psum_buf_valid,
  input  logic [DATA_WIDTH-1:0]        psum_buf_dout,
  output logic                         psum_buf_ren,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   err_code,
  input  logic                         err_clear
);

  localparam logic [COUNT_WIDTH-1:0]   CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] WDOG_ONE = TIMEOUT_WIDTH'(1);

  seq_state_e                   state_q, state_d;
  logic [STRIDE_WIDTH-1:0]      stride_q, stride_d;
  logic [FILTER_SIZE_WIDTH-1:0] fsize_q, fsize_d;
  logic [COUNT_WIDTH-1:0]       count_q, count_d;
  logic [COUNT_WIDTH-1:0]       prod_cnt_q, prod_cnt_d, prod_inc;
  logic [TIMEOUT_WIDTH-1:0]     wdog_q, wdog_d, wdog_inc;
  logic [1:0]                   err_q, err_d;
  logic accept, bad_cfg, timeout, overrun, drain_done;

  assign job_ready      = (state_q == ST_IDLE) && (err_q == ERR_NONE);
  assign accept         = job_valid & job_ready;
  assign pe_start       = (state_q == ST_START);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign pe_stride      = stride_q;
  assign pe_filter_size = fsize_q;
  assign err_code       = err_q;
  assign prod_inc       = prod_cnt_q + CNT_ONE;
  assign wdog_inc       = wdog_q + WDOG_ONE;

  psum_drain_counter #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_drain (
    .clk_i        (clk),
    .rst_ni       (rst),
    .en_i         (is_drain_phase(state_q)),
    .clr_i        (accept),
    .count_i      (count_q),
    .buf_valid_i  (psum_buf_valid),
    .buf_dout_i   (psum_buf_dout),
    .out_ready_i  (out_ready),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .buf_ren_o    (psum_buf_ren),
    .drain_done_o (drain_done)
  );

  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    fsize_d    = fsize_q;
    count_d    = count_q;
    prod_cnt_d = prod_cnt_q;
    wdog_d     = wdog_q;
    bad_cfg    = 1'b0;
    timeout    = 1'b0;
    overrun    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        overrun = pe_wen_psum;
        if (accept) begin
          stride_d   = job_stride;
          fsize_d    = job_filter_size;
          count_d    = job_psum_count;
          prod_cnt_d = '0;
          wdog_d     = '0;
          if ((job_filter_size == '0) || (job_psum_count == '0)) begin
            bad_cfg = 1'b1;
            state_d = ST_ERR;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (pe_wen_psum) begin
          prod_cnt_d = prod_inc;
          wdog_d     = '0;
          if (prod_inc == count_q) state_d = ST_DRAIN;
        end else begin
          // Fires once the count of consecutive idle RUN cycles reaches all-ones.
          wdog_d = wdog_inc;
          if (wdog_inc == '1) begin
            timeout = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
      ST_DRAIN: begin
        overrun = pe_wen_psum;
        if (drain_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        overrun = pe_wen_psum;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (err_clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = err_q;
    if (err_clear)    err_d = ERR_NONE;
    else if (bad_cfg) err_d = ERR_BAD_CFG;
    else if (timeout) err_d = ERR_TIMEOUT;
    else if (overrun) err_d = ERR_OVERRUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      stride_q   <= '0;
      fsize_q    <= '0;
      count_q    <= '0;
      prod_cnt_q <= '0;
      wdog_q     <= '0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      stride_q   <= stride_d;
      fsize_q    <= fsize_d;
      count_q    <= count_d;
      prod_cnt_q <= prod_cnt_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
    end
  end

endmodule
